// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine.
//   MemAddrW / MemDataW : default address and data widths
//   copy_state_e        : copy FSM state encoding (idle, read, write, done)
package mem_pkg;

  localparam int unsigned MemAddrW = 16;
  localparam int unsigned MemDataW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } copy_state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory-port bundle between the copy engine (master) and data_memory (slave).
//   mem_address    : word address driven by the initiator
//   mem_write_data : write data driven by the initiator
//   memWrite       : write strobe
//   memRead        : read strobe
//   read_data      : read data returned by the memory
interface mem_copy_engine_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW,
  parameter int unsigned DATA_W = MemDataW
) ();

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] read_data;

  modport master (
    output mem_address,
    output mem_write_data,
    output memWrite,
    output memRead,
    input  read_data
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  memWrite,
    input  memRead,
    output read_data
  );

endinterface

// File: rtl/mem_copy_addr_gen.sv
// Source/destination pointer and remaining-count registers for the copy engine.
//   clock, reset : system clock, asynchronous active-high reset
//   load         : latch src_addr/dst_addr/length (accepted start)
//   incr         : advance both pointers and decrement the count (write cycle)
//   src, dst     : current pointers
//   src_nxt      : src + 1 (modulo 2**ADDR_W), used to pre-drive the next read address
//   last         : remaining count is 1, i.e. the current word is the final one
module mem_copy_addr_gen
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              incr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] src_nxt,
  output logic              last
);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] rem_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      rem_q <= length;
    end else if (incr) begin
      // Pointers wrap naturally at the register width.
      src_q <= src_q + ADDR_W'(1);
      dst_q <= dst_q + ADDR_W'(1);
      rem_q <= rem_q - ADDR_W'(1);
    end
  end

  assign src     = src_q;
  assign dst     = dst_q;
  assign src_nxt = src_q + ADDR_W'(1);
  assign last    = (rem_q == ADDR_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Bus initiator that copies `length` words from src_addr to dst_addr through data_memory,
// one read then one write per word, in ascending address order.
//   clock, reset      : system clock, asynchronous active-high reset
//   start             : one-cycle request, sampled only while idle
//   src_addr/dst_addr : first source/destination word address (latched on start)
//   length            : word count (latched on start), 0 means no transfer
//   busy              : high from the cycle after an accepted start through the done cycle
//   done              : one-cycle completion pulse
//   checksum          : (MEM_COPY_CHECKSUM_EN only) modular sum of all words written
//   bus               : memory port (master side)
// Optional build macro: MEM_COPY_CHECKSUM_EN adds the checksum output and its adder.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = MemAddrW,
  parameter int unsigned DATA_W       = MemDataW,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  mem_copy_engine_if.master bus
);

  localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  copy_state_e       state_q;
  logic [LatW-1:0]   lat_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic              done_q;

  logic              load;
  logic              incr;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src_nxt;
  logic              last;

  assign load = (state_q == StIdle) && start;
  assign incr = (state_q == StWrite);

  mem_copy_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .incr     (incr),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .src      (src),
    .dst      (dst),
    .src_nxt  (src_nxt),
    .last     (last)
  );

  // Outputs are registered: each transition loads the values for the state being entered.
  // The first read address comes straight from src_addr because the pointer loads on the
  // same edge; later reads use src_nxt since the pointer increments on the write edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lat_cnt_q     <= '0;
      data_q        <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q    <= 1'b1;
            lat_cnt_q <= '0;
            if (length != '0) begin
              state_q       <= StRead;
              mem_read_q    <= 1'b1;
              mem_address_q <= src_addr;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (lat_cnt_q == LatW'(READ_LATENCY - 1)) begin
            data_q        <= bus.read_data;
            state_q       <= StWrite;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b1;
            mem_address_q <= dst;
            lat_cnt_q     <= '0;
          end else begin
            lat_cnt_q <= lat_cnt_q + LatW'(1);
          end
        end
        StWrite: begin
          mem_write_q <= 1'b0;
          if (last) begin
            state_q       <= StDone;
            done_q        <= 1'b1;
            mem_address_q <= '0;
          end else begin
            state_q       <= StRead;
            mem_read_q    <= 1'b1;
            mem_address_q <= src_nxt;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (load) begin
      checksum_q <= '0;
    end else if (state_q == StWrite) begin
      checksum_q <= checksum_q + data_q;
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = data_q;
  assign bus.memRead        = mem_read_q;
  assign bus.memWrite       = mem_write_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with an inline data_memory model (combinational read,
// clocked write) and a scoreboard of expected writes checked as the engine issues them.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy;
  logic        done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_copy_engine #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .READ_LATENCY (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (bus)
  );

  always #5 clock = ~clock;

  // Memory model
  bit   [15:0] mem [65536];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign bus.read_data = bus.memRead ? mem[bus.mem_address] : 16'h0000;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.memWrite) mem[bus.mem_address] <= bus.mem_write_data;
  end

  // Scoreboard and counters
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  done_cnt = 0;
  int  access_cnt = 0;
  int  write_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (bus.memRead || bus.memWrite) access_cnt++;
      if (bus.memWrite) begin
        write_cnt++;
        check("wr_no_read", 32'(bus.memRead), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(bus.mem_address), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_address), 32'(e.addr));
          check("wr_data", 32'(bus.mem_write_data), 32'(e.data));
        end
      end
    end
  end

  task automatic mem_set(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of cycle 1 after the accepting edge.
  task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clock);
    start = 1'b1; src_addr = s; dst_addr = d; length = l;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output int cyc);
    cyc = base;
    while (!done && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    int a0;
    int w0;

    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_memRead", 32'(bus.memRead), 32'h0);
    check("rst_memWrite", 32'(bus.memWrite), 32'h0);
    check("rst_addr", 32'(bus.mem_address), 32'h0);
    check("rst_wdata", 32'(bus.mem_write_data), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Length 0: done in the next cycle, no memory access
    mem_set(16'h0008, 16'h1234);
    a0 = access_cnt;
    kick(16'h0000, 16'h0008, 16'h0000);
    wait_done(1, 10, cyc);
    check("len0_done_cycle", 32'(cyc), 32'd1);
    check("len0_busy", 32'(busy), 32'h1);
    @(negedge clock);
    check("len0_done_drop", 32'(done), 32'h0);
    check("len0_idle", 32'(busy), 32'h0);
    check("len0_no_access", 32'(access_cnt - a0), 32'h0);
    check("len0_mem8", 32'(mem[16'h0008]), 32'h1234);

    // Basic copy
    for (int i = 0; i < 4; i++) mem_set(16'(i), 16'(i + 1));
    for (int i = 0; i < 4; i++) expect_wr(16'(16 + i), 16'(i + 1));
    kick(16'h0000, 16'h0010, 16'h0004);
    check("basic_busy_c1", 32'(busy), 32'h1);
    check("basic_read_c1", 32'(bus.memRead), 32'h1);
    wait_done(1, 40, cyc);
    check("basic_done_cycle", 32'(cyc), 32'd9);
`ifdef MEM_COPY_CHECKSUM_EN
    check("basic_checksum", 32'(checksum), 32'd10);
`endif
    check("basic_done_addr", 32'(bus.mem_address), 32'h0);
    @(negedge clock);
    check("basic_idle_busy", 32'(busy), 32'h0);
    check("basic_idle_done", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) check("basic_mem", 32'(mem[16'(16 + i)]), 32'(i + 1));
    check("basic_q_empty", 32'(exp_q.size()), 32'h0);

    // Address wrap
    mem_set(16'hFFFF, 16'hAAAA);
    mem_set(16'h0000, 16'h5555);
    expect_wr(16'h0100, 16'hAAAA);
    expect_wr(16'h0101, 16'h5555);
    kick(16'hFFFF, 16'h0100, 16'h0002);
    wait_done(1, 40, cyc);
    check("wrap_done_cycle", 32'(cyc), 32'd5);
    @(negedge clock);
    check("wrap_mem100", 32'(mem[16'h0100]), 32'hAAAA);
    check("wrap_mem101", 32'(mem[16'h0101]), 32'h5555);
    check("wrap_q_empty", 32'(exp_q.size()), 32'h0);

    // Start while busy is ignored
    for (int i = 0; i < 3; i++) mem_set(16'(16'h20 + i), 16'(16'hC0 + i));
    mem_set(16'h0040, 16'hDEAD);
    mem_set(16'h0300, 16'hBEEF);
    for (int i = 0; i < 3; i++) expect_wr(16'(16'h200 + i), 16'(16'hC0 + i));
    d0 = done_cnt;
    kick(16'h0020, 16'h0200, 16'h0003);
    @(negedge clock);
    start = 1'b1; src_addr = 16'h0040; dst_addr = 16'h0300; length = 16'h0001;
    @(negedge clock);
    start = 1'b0;
    wait_done(3, 40, cyc);
    check("busy_done_cycle", 32'(cyc), 32'd7);
    repeat (8) @(negedge clock);
    check("busy_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_idle", 32'(busy), 32'h0);
    check("busy_mem300", 32'(mem[16'h0300]), 32'hBEEF);
    for (int i = 0; i < 3; i++) check("busy_mem", 32'(mem[16'(16'h200 + i)]), 32'(16'hC0 + i));
    check("busy_q_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-copy after the third write
    for (int i = 0; i < 8; i++) mem_set(16'(16'h50 + i), 16'(16'h700 + i));
    for (int i = 0; i < 3; i++) expect_wr(16'(16'h400 + i), 16'(16'h700 + i));
    d0 = done_cnt;
    w0 = write_cnt;
    kick(16'h0050, 16'h0400, 16'h0008);
    cyc = 1;
    while (write_cnt - w0 < 3 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("rstmid_third_write", 32'(write_cnt - w0), 32'd3);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_done", 32'(done), 32'h0);
    check("rstmid_memRead", 32'(bus.memRead), 32'h0);
    check("rstmid_memWrite", 32'(bus.memWrite), 32'h0);
    check("rstmid_addr", 32'(bus.mem_address), 32'h0);
    check("rstmid_wdata", 32'(bus.mem_write_data), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 3; i++) check("rstmid_mem", 32'(mem[16'(16'h400 + i)]), 32'(16'h700 + i));
    check("rstmid_untouched", 32'(mem[16'h0403]), 32'h0);
    check("rstmid_q_empty", 32'(exp_q.size()), 32'h0);

`ifdef MEM_COPY_CHECKSUM_EN
    // Checksum wraps modulo 2**16
    mem_set(16'h0060, 16'hFFFF);
    mem_set(16'h0061, 16'h0002);
    expect_wr(16'h0500, 16'hFFFF);
    expect_wr(16'h0501, 16'h0002);
    kick(16'h0060, 16'h0500, 16'h0002);
    wait_done(1, 40, cyc);
    check("cks_done_cycle", 32'(cyc), 32'd5);
    check("cks_wrap", 32'(checksum), 32'h0001);
    repeat (3) @(negedge clock);
    check("cks_hold", 32'(checksum), 32'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
